// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory stage of the pipelined CPU plus the MEM/WB pipeline register.
//   Performs data-memory and memory-mapped I/O loads/stores. It also owns
//   the board I/O registers (LEDR, HEX) and the KEY/SW input synchronizers.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   en                      stage advance enable (0 = hold)
//   alu_res_in              ALU result / effective address
//   store_data_in           store value
//   dst_ind_in              destination register index
//   mem_wrt_en_in           store
//   mem_rd_en_in            load
//   reg_file_wrt_en_in      instruction writes the register file
//   key_in, sw_in           asynchronous board inputs
//   wb_data_out             write-back value
//   dst_ind_out             registered destination index
//   reg_file_wrt_en_out     registered register-file write enable
//   ledr_out, hex_out       board output registers
module mem_wb_stage #(
  parameter int          BIT_WIDTH           = 32,
  parameter int          REG_INDEX_BIT_WIDTH = 4,
  parameter int          DMEM_ADDR_BIT_WIDTH = 11,
  parameter logic [31:0] IO_LEDR_ADDR        = 32'hF0000000,
  parameter logic [31:0] IO_HEX_ADDR         = 32'hF0000004,
  parameter logic [31:0] IO_KEY_ADDR         = 32'hF0000010,
  parameter logic [31:0] IO_SW_ADDR          = 32'hF0000014
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [BIT_WIDTH-1:0]           alu_res_in,
  input  logic [BIT_WIDTH-1:0]           store_data_in,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_in,
  input  logic                           mem_wrt_en_in,
  input  logic                           mem_rd_en_in,
  input  logic                           reg_file_wrt_en_in,
  input  logic [3:0]                     key_in,
  input  logic [9:0]                     sw_in,
  output logic [BIT_WIDTH-1:0]           wb_data_out,
  output logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_out,
  output logic                           reg_file_wrt_en_out,
  output logic [9:0]                     ledr_out,
  output logic [15:0]                    hex_out
);

  localparam int DMEM_WORDS = 1 << DMEM_ADDR_BIT_WIDTH;

  // MEM/WB payload
  typedef struct packed {
    logic [REG_INDEX_BIT_WIDTH-1:0] dst;
    logic                           rf_wen;
    logic                           ld;
    logic                           io;
    logic [BIT_WIDTH-1:0]           alu;
    logic [BIT_WIDTH-1:0]           io_rd;
  } mem_wb_t;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic                           is_io;
  logic [DMEM_ADDR_BIT_WIDTH-1:0] word_idx;
  logic                           adv;

  assign is_io    = (alu_res_in[BIT_WIDTH-1 -: 4] == 4'hF);
  // Byte offset and bits above the index are dropped, so addresses alias.
  assign word_idx = alu_res_in[DMEM_ADDR_BIT_WIDTH+1:2];
  // Reset wins over en for every write and register update.
  assign adv      = en && !reset;

  // ---------------------------------------------------------------------
  // Input synchronizers (free-running, not gated by en)
  // ---------------------------------------------------------------------
  logic [3:0] key_s1, key_s2;
  logic [9:0] sw_s1, sw_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_in;
      key_s2 <= key_s1;
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
    end
  end

  // ---------------------------------------------------------------------
  // Board output registers
  // ---------------------------------------------------------------------
  logic [9:0]  ledr_q;
  logic [15:0] hex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ledr_q <= '0;
      hex_q  <= '0;
    end else if (en && mem_wrt_en_in && is_io) begin
      if (alu_res_in == IO_LEDR_ADDR) ledr_q <= store_data_in[9:0];
      if (alu_res_in == IO_HEX_ADDR)  hex_q  <= store_data_in[15:0];
    end
  end

  assign ledr_out = ledr_q;
  assign hex_out  = hex_q;

  // I/O read mux. It sees the register values from before any store on
  // the same edge, which matches the RAM's read-old-data behaviour.
  logic [BIT_WIDTH-1:0] io_rd;

  always_comb begin
    io_rd = '0;
    if (alu_res_in == IO_LEDR_ADDR)     io_rd = {{(BIT_WIDTH-10){1'b0}}, ledr_q};
    else if (alu_res_in == IO_HEX_ADDR) io_rd = {{(BIT_WIDTH-16){1'b0}}, hex_q};
    else if (alu_res_in == IO_KEY_ADDR) io_rd = {{(BIT_WIDTH-4){1'b0}}, key_s2};
    else if (alu_res_in == IO_SW_ADDR)  io_rd = {{(BIT_WIDTH-10){1'b0}}, sw_s2};
  end

  // ---------------------------------------------------------------------
  // Data memory: single-port synchronous RAM, contents never reset.
  // The read register holds across stalls, so the write-back mux stays
  // stable while en=0. A simultaneous read/write returns the old word.
  // ---------------------------------------------------------------------
  logic [BIT_WIDTH-1:0] dmem [DMEM_WORDS];
  logic [BIT_WIDTH-1:0] ram_rd;

  always_ff @(posedge clk) begin
    if (adv && mem_wrt_en_in && !is_io) dmem[word_idx] <= store_data_in;
    if (en) ram_rd <= dmem[word_idx];
  end

  // ---------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------
  mem_wb_t wb_q, wb_d;

  always_comb begin
    wb_d        = '0;
    wb_d.dst    = dst_ind_in;
    wb_d.rf_wen = reg_file_wrt_en_in;
    wb_d.ld     = mem_rd_en_in;
    wb_d.io     = is_io;
    wb_d.alu    = alu_res_in;
    wb_d.io_rd  = io_rd;
  end

  always_ff @(posedge clk) begin
    if (reset)   wb_q <= '0;
    else if (en) wb_q <= wb_d;
  end

  // After reset ld=0 and alu=0, so wb_data_out reads 0 whatever ram_rd holds.
  assign wb_data_out         = wb_q.ld ? (wb_q.io ? wb_q.io_rd : ram_rd) : wb_q.alu;
  assign dst_ind_out         = wb_q.dst;
  assign reg_file_wrt_en_out = wb_q.rf_wen;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] alu_res_in, store_data_in;
  logic [3:0]  dst_ind_in;
  logic        mem_wrt_en_in, mem_rd_en_in, reg_file_wrt_en_in;
  logic [3:0]  key_in;
  logic [9:0]  sw_in;
  logic [31:0] wb_data_out;
  logic [3:0]  dst_ind_out;
  logic        reg_file_wrt_en_out;
  logic [9:0]  ledr_out;
  logic [15:0] hex_out;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .en(en),
    .alu_res_in(alu_res_in), .store_data_in(store_data_in),
    .dst_ind_in(dst_ind_in), .mem_wrt_en_in(mem_wrt_en_in),
    .mem_rd_en_in(mem_rd_en_in), .reg_file_wrt_en_in(reg_file_wrt_en_in),
    .key_in(key_in), .sw_in(sw_in),
    .wb_data_out(wb_data_out), .dst_ind_out(dst_ind_out),
    .reg_file_wrt_en_out(reg_file_wrt_en_out),
    .ledr_out(ledr_out), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dst;
    logic        wen;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Monitor: every accepted (en=1, reset=0) edge produces one MEM/WB result.
  always @(posedge clk) begin
    if (en === 1'b1 && reset === 1'b0) begin
      #1;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".data"}, wb_data_out, e.data);
        chk({e.name, ".dst"}, {28'd0, dst_ind_out}, {28'd0, e.dst});
        chk({e.name, ".wen"}, {31'd0, reg_file_wrt_en_out}, {31'd0, e.wen});
      end
    end
  end

  // Issue one accepted op and queue its expected write-back.
  task automatic op(input string name, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] dst, input logic wr, input logic rd,
                    input logic rfw, input logic [31:0] exp_data);
    exp_t e;
    reset = 1'b0; en = 1'b1;
    alu_res_in = a; store_data_in = d; dst_ind_in = dst;
    mem_wrt_en_in = wr; mem_rd_en_in = rd; reg_file_wrt_en_in = rfw;
    if (wr && rd) $display("warning: %s has load and store together", name);
    e.data = exp_data; e.dst = dst; e.wen = rfw; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic st(input string n, input logic [31:0] a, input logic [31:0] d);
    op(n, a, d, 4'd0, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic ld(input string n, input logic [31:0] a, input logic [3:0] dst,
                    input logic [31:0] exp_data);
    op(n, a, 32'h0, dst, 1'b0, 1'b1, 1'b1, exp_data);
  endtask

  // Stalled cycle: present a store with en=0 (or reset if rst=1).
  task automatic idle(input logic rst, input logic e, input logic [31:0] a,
                      input logic [31:0] d);
    reset = rst; en = e;
    alu_res_in = a; store_data_in = d; dst_ind_in = 4'd9;
    mem_wrt_en_in = 1'b1; mem_rd_en_in = 1'b0; reg_file_wrt_en_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string n);
    chk({n, ".wb"}, wb_data_out, 32'h0);
    chk({n, ".dst"}, {28'd0, dst_ind_out}, 32'h0);
    chk({n, ".wen"}, {31'd0, reg_file_wrt_en_out}, 32'h0);
    chk({n, ".ledr"}, {22'd0, ledr_out}, 32'h0);
    chk({n, ".hex"}, {16'd0, hex_out}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0;
    alu_res_in = '0; store_data_in = '0; dst_ind_in = '0;
    mem_wrt_en_in = 1'b0; mem_rd_en_in = 1'b0; reg_file_wrt_en_in = 1'b0;
    key_in = 4'h0; sw_in = 10'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");

    // Store then load on the next cycle
    st("st_10", 32'h00000010, 32'hDEADBEEF);
    ld("ld_10", 32'h00000010, 4'd3, 32'hDEADBEEF);

    // Board output registers and their readback
    st("st_ledr", 32'hF0000000, 32'h000003FF);
    chk("ledr_after_store", {22'd0, ledr_out}, 32'h3FF);
    st("st_hex", 32'hF0000004, 32'h0000ABCD);
    chk("hex_after_store", {16'd0, hex_out}, 32'hABCD);
    ld("ld_ledr", 32'hF0000000, 4'd5, 32'h3FF);
    ld("ld_hex", 32'hF0000004, 4'd6, 32'hABCD);
    ld("ld_io_other", 32'hF0000008, 4'd7, 32'h0);
    // Plain ALU op: write-back is the ALU result
    op("alu_op", 32'h12340000, 32'h0, 4'd8, 1'b0, 1'b0, 1'b1, 32'h12340000);

    // SW synchronizer latency: edges 1 and 2 after the change see old value
    sw_in = 10'h155;
    ld("ld_sw_e1", 32'hF0000014, 4'd1, 32'h0);
    ld("ld_sw_e2", 32'hF0000014, 4'd1, 32'h0);
    ld("ld_sw_e3", 32'hF0000014, 4'd1, 32'h155);
    key_in = 4'hA;
    op("nop_a", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    op("nop_b", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    ld("ld_key", 32'hF0000010, 4'd2, 32'hA);

    // Stall: no writes, outputs and RAM read data hold
    st("st_20_old", 32'h00000020, 32'h11111111);
    ld("ld_10_pre_stall", 32'h00000010, 4'd7, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 1'b0, 32'h00000020, 32'h12345678);
      chk("stall_hold.wb", wb_data_out, 32'hDEADBEEF);
      chk("stall_hold.dst", {28'd0, dst_ind_out}, 32'd7);
      chk("stall_hold.wen", {31'd0, reg_file_wrt_en_out}, 32'd1);
    end
    idle(1'b0, 1'b0, 32'hF0000000, 32'h0);
    chk("stall_ledr_hold", {22'd0, ledr_out}, 32'h3FF);
    ld("ld_20_after_stall", 32'h00000020, 4'd4, 32'h11111111);
    st("st_20_new", 32'h00000020, 32'h12345678);
    ld("ld_20_new", 32'h00000020, 4'd4, 32'h12345678);

    // Reset with stores presented: both suppressed, outputs clear
    idle(1'b1, 1'b1, 32'hF0000000, 32'h000000AA);
    chk_zero("reset_with_store");
    idle(1'b1, 1'b1, 32'h00000010, 32'h00000BAD);
    ld("ld_key_after_reset", 32'hF0000010, 4'd2, 32'h0);
    ld("ld_10_after_reset", 32'h00000010, 4'd3, 32'hDEADBEEF);

    // Reset during a stall, then resume
    idle(1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b1, 1'b0, 32'hF0000004, 32'h5555);
    chk_zero("reset_mid_stall");
    ld("resume_after_reset", 32'h00000020, 4'd5, 32'h12345678);

    // Aliasing: word 2048 wraps to word 0; byte offset ignored
    st("st_alias", 32'h00002000, 32'hCAFEF00D);
    ld("ld_alias_0", 32'h00000000, 4'd9, 32'hCAFEF00D);
    ld("ld_alias_off", 32'h00002003, 4'd9, 32'hCAFEF00D);

    // Illegal load+store: store lands, load returns old data
    st("st_40", 32'h00000040, 32'h00000001);
    op("ldst_40", 32'h00000040, 32'h00000002, 4'd10, 1'b1, 1'b1, 1'b1, 32'h00000001);
    ld("ld_40", 32'h00000040, 4'd11, 32'h00000002);

    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory stage of the pipelined CPU, directly downstream of the EXE/MEM pipeline buffer. It takes the ALU result, store data, destination index and control bits held in that buffer and performs data-memory or memory-mapped I/O loads and stores. It registers the write-back payload (MEM/WB boundary) for the register file. It also owns the board I/O registers: LEDR and HEX outputs, and synchronized KEY and SW inputs.

## Interface
Parameters:
- BIT_WIDTH, 32, datapath width
- REG_INDEX_BIT_WIDTH, 4, register index width
- DMEM_ADDR_BIT_WIDTH, 11, word-address width of data memory (2048 words)
- IO_LEDR_ADDR, 32'hF0000000; IO_HEX_ADDR, 32'hF0000004; IO_KEY_ADDR, 32'hF0000010; IO_SW_ADDR, 32'hF0000014

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  stage advance enable (0 = stall/hold)
- alu_res_in  in  BIT_WIDTH  ALU result / effective address
- store_data_in  in  BIT_WIDTH  store value (already forwarded)
- dst_ind_in  in  REG_INDEX_BIT_WIDTH  destination register index
- mem_wrt_en_in  in  1  store
- mem_rd_en_in  in  1  load
- reg_file_wrt_en_in  in  1  instruction writes register file
- key_in  in  4  board keys (asynchronous)
- sw_in  in  10  board switches (asynchronous)
- wb_data_out  out  BIT_WIDTH  write-back value
- dst_ind_out  out  REG_INDEX_BIT_WIDTH  registered destination index
- reg_file_wrt_en_out  out  1  registered register-file write enable
- ledr_out  out  10  LED register
- hex_out  out  16  four 4-bit HEX digit codes

## Operation
- Address decode on alu_res_in: bits [31:28] == 4'hF selects I/O; otherwise data memory, word index = alu_res_in[DMEM_ADDR_BIT_WIDTH+1:2]. Low two bits are ignored. Upper bits above the index are ignored, so addresses alias (wrap) modulo memory size.
- Data memory: single-port synchronous RAM with no reset of contents. A store writes store_data_in at the edge when en=1, reset=0 and mem_wrt_en_in=1.
- I/O stores under the same qualification:
  - LEDR address: ledr_out <= store_data_in[9:0]
  - HEX address: hex_out <= store_data_in[15:0]
  - Any other I/O address: no effect (KEY/SW are read-only).
- I/O loads:
  - KEY returns {28'b0, key_sync}; SW returns {22'b0, sw_sync}.
  - LEDR and HEX read back their current register values, zero-extended.
  - Any other I/O address returns 0.
- key_in and sw_in each pass through a 2-flop synchronizer clocked every cycle, independent of en. Reset clears both stages.
- The MEM/WB register captures dst_ind_in, reg_file_wrt_en_in, alu_res_in, load flag, I/O-select and I/O read value when en=1.
  - wb_data_out = registered load flag ? (registered I/O-select ? registered I/O read value : RAM read data) : registered alu result.
- If mem_rd_en_in and mem_wrt_en_in are both 1 (illegal encoding), the store takes effect and the load returns old (pre-write) data. The bench flags this case as a warning.

## Timing
- Latency: inputs presented with en=1 at edge N appear on dst_ind_out, reg_file_wrt_en_out and wb_data_out after edge N; stores are visible to a load issued at N+1.
- Load-after-store to the same address in consecutive cycles returns the new value.
- en=0: no RAM or I/O writes; all MEM/WB outputs and the RAM read output hold their values; synchronizers keep running.
- Reset (synchronous, wins over en):
  - wb_data_out=0, dst_ind_out=0, reg_file_wrt_en_out=0, ledr_out=0, hex_out=0, synchronizers=0.
  - Any store presented in the reset cycle is suppressed.
  - RAM contents are unchanged by reset.
- Reset asserted mid-stall: outputs clear at that edge; after reset deasserts, the stage resumes with whatever is on the inputs when en=1.
- Input sync latency: a key/sw change appears on a load result no earlier than 2 edges later.

## Test plan
- Store 32'hDEADBEEF to 32'h00000010, then load 32'h00000010 on the next cycle -> wb_data_out=32'hDEADBEEF one cycle after the load, reg_file_wrt_en_out=1.
- Store 32'h000003FF to 32'hF0000000 and 32'h0000ABCD to 32'hF0000004 -> ledr_out=10'h3FF, hex_out=16'hABCD after the edge; loading both addresses reads them back.
- Set sw_in=10'h155, then load 32'hF0000014 -> returns 32'h155 only if issued at least 2 edges after the change; a load 1 edge after returns the old value.
- Assert the store to 32'h20 with en=0, then with en=1 -> memory changes only on the en=1 edge; all outputs hold during en=0.
- Present the store to 32'hF0000000 together with reset=1 -> ledr_out=0, store suppressed; all outputs read 0 after the edge.
- Store to word index 2048 (address 32'h2000), load 32'h0 -> aliased value returned.
